// File: rtl/spi_slave.sv
// SPI slave front end for the 256x8 RAM: deserialises 10-bit command words from MOSI
// and serialises the RAM read response onto MISO during read-data frames.
module spi_slave #(
   parameter int WORD_W = 10,
   parameter int TX_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [TX_W-1:0]   tx_data,
   input  logic              tx_valid
);

   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam int TXC_W = $clog2(TX_W);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [WORD_W-2:0] shift_r;
   logic [TXC_W-1:0]  tx_cnt_r;
   logic              tx_busy_r;
   logic              rd_addr_ok_r;
   logic              sent_r;

   logic              word_busy_s;
   logic              last_bit_s;
   logic              in_frame_s;
   logic [WORD_W-1:0] word_s;

   assign word_busy_s = (cnt_r != CNT_W'(WORD_W));
   assign last_bit_s  = (cnt_r == CNT_W'(WORD_W - 1));
   assign in_frame_s  = (state_r == WRITE) || (state_r == READ_ADD) || (state_r == READ_DATA);
   // The 10th bit is taken straight from MOSI, so only the first nine are stored.
   assign word_s      = {shift_r, MOSI};

   // Frame sequencing, word capture and response serialisation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         shift_r      <= {(WORD_W-1){1'b0}};
         tx_cnt_r     <= {TXC_W{1'b0}};
         tx_busy_r    <= 1'b0;
         rd_addr_ok_r <= 1'b0;
         sent_r       <= 1'b0;
         MISO         <= 1'b0;
         rx_data      <= {WORD_W{1'b0}};
         rx_valid     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (SS_n) begin
            // rd_addr_ok survives deselect so an aborted read can be retried.
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            sent_r    <= 1'b0;
            tx_busy_r <= 1'b0;
            MISO      <= 1'b0;
         end else if (in_frame_s && word_busy_s) begin
            shift_r <= word_s[WORD_W-2:0];
            cnt_r   <= cnt_r + CNT_W'(1'b1);
            if (last_bit_s) begin
               rx_data  <= word_s;
               rx_valid <= 1'b1;
               if (state_r == READ_ADD) begin
                  rd_addr_ok_r <= 1'b1;
               end
            end
         end else begin
            case (state_r)
               IDLE: begin
                  state_r <= CHK_CMD;
               end
               CHK_CMD: begin
                  if (!MOSI) begin
                     state_r <= WRITE;
                  end else if (rd_addr_ok_r) begin
                     state_r <= READ_DATA;
                  end else begin
                     state_r <= READ_ADD;
                  end
               end
               WRITE, READ_ADD: begin
                  state_r <= state_r;
               end
               READ_DATA: begin
                  if (tx_busy_r) begin
                     if (tx_cnt_r != {TXC_W{1'b0}}) begin
                        MISO     <= shift_r[TX_W-2];
                        shift_r  <= {shift_r[WORD_W-3:0], 1'b0};
                        tx_cnt_r <= tx_cnt_r - TXC_W'(1'b1);
                     end else begin
                        MISO         <= 1'b0;
                        tx_busy_r    <= 1'b0;
                        sent_r       <= 1'b1;
                        rd_addr_ok_r <= 1'b0;
                     end
                  end else if (!sent_r && tx_valid) begin
                     MISO      <= tx_data[TX_W-1];
                     shift_r   <= {{(WORD_W-1-TX_W){1'b0}}, tx_data};
                     tx_cnt_r  <= TXC_W'(TX_W - 1);
                     tx_busy_r <= 1'b1;
                  end else begin
                     MISO <= 1'b0;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  MISO    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: expected words and MISO bits are queued as stimulus
// is driven and compared cycle-by-cycle as the DUT produces them.
module tb_spi_slave;

   logic       clk;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   typedef struct {
      logic [9:0] data;
      int         cyc;
   } rx_exp_t;

   rx_exp_t rx_q[$];
   logic    miso_q[$];
   int      checks = 0;
   int      errors = 0;
   int      cyc    = 0;

   spi_slave #(.WORD_W(10), .TX_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc %0d observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock edge: drive at negedge, compare just after the posedge.
   task automatic step(input logic ss, input logic mosi);
      rx_exp_t e;
      logic    exp_miso;
      @(negedge clk);
      SS_n = ss;
      MOSI = mosi;
      @(posedge clk);
      #1;
      cyc++;
      if (rx_q.size() != 0 && rx_q[0].cyc == cyc) begin
         e = rx_q.pop_front();
         chk("rx_valid_pulse", {9'd0, rx_valid}, 10'd1);
         chk("rx_data", rx_data, e.data);
      end else begin
         chk("rx_valid_idle", {9'd0, rx_valid}, 10'd0);
      end
      if (miso_q.size() != 0) begin
         exp_miso = miso_q.pop_front();
      end else begin
         exp_miso = 1'b0;
      end
      chk("miso", {9'd0, MISO}, {9'd0, exp_miso});
   endtask

   task automatic frame_start(input logic sel);
      step(1'b0, 1'b0);
      step(1'b0, sel);
   endtask

   task automatic send_word(input logic [9:0] w, input int nbits);
      rx_exp_t e;
      for (int i = 0; i < nbits; i++) begin
         if (i == 9) begin
            e.data = w;
            e.cyc  = cyc + 1;
            rx_q.push_back(e);
         end
         step(1'b0, w[9-i]);
      end
   endtask

   task automatic push_tx(input logic [7:0] d, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         miso_q.push_back(d[7-i]);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic frame_end();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
   endtask

   initial begin
      rst_n    = 1'b0;
      SS_n     = 1'b1;
      MOSI     = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_miso", {9'd0, MISO}, 10'd0);
      chk("reset_rx_valid", {9'd0, rx_valid}, 10'd0);
      chk("reset_rx_data", rx_data, 10'h000);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0);

      // Write address and write data frames; trailing MOSI is ignored.
      frame_start(1'b0); send_word(10'h03A, 10); run(3); frame_end();
      frame_start(1'b0); send_word(10'h1C5, 10); run(3); frame_end();

      // Read address with tx_valid already high: no response in READ_ADD.
      tx_data = 8'hA5; tx_valid = 1'b1;
      frame_start(1'b1); send_word(10'h210, 10); run(4); frame_end();
      // Read data: response follows the word, exactly once.
      frame_start(1'b1); send_word(10'h300, 10); push_tx(8'hA5, 8); run(8); run(5); frame_end();
      // rd_addr_ok cleared, so this is READ_ADD again.
      frame_start(1'b1); send_word(10'h155, 10); run(4); frame_end();

      // Aborted write, then a full one.
      frame_start(1'b0); send_word(10'h2F0, 5); frame_end();
      frame_start(1'b0); send_word(10'h07F, 10); run(2); frame_end();

      // READ_DATA aborted after 3 bits, then retried with late tx_valid.
      tx_data = 8'h3C;
      frame_start(1'b1); send_word(10'h3FF, 10); push_tx(8'h3C, 3); run(3); frame_end();
      tx_valid = 1'b0; tx_data = 8'hC3;
      frame_start(1'b1); send_word(10'h0F0, 10); run(2);
      tx_valid = 1'b1; push_tx(8'hC3, 8); run(8); run(3); frame_end();

      // Reset during READ_DATA bit 4.
      tx_valid = 1'b0;
      frame_start(1'b1); send_word(10'h2AA, 10); run(1); frame_end();
      tx_data = 8'h5A; tx_valid = 1'b1;
      frame_start(1'b1); send_word(10'h301, 10); push_tx(8'h5A, 4); run(4);
      @(negedge clk);
      rst_n = 1'b0;
      SS_n  = 1'b1;
      #1;
      chk("midreset_miso", {9'd0, MISO}, 10'd0);
      chk("midreset_rx_valid", {9'd0, rx_valid}, 10'd0);
      chk("midreset_rx_data", rx_data, 10'h000);
      miso_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0);
      frame_start(1'b1); send_word(10'h2CC, 10); run(4); frame_end();
      tx_data = 8'h81;
      frame_start(1'b1); send_word(10'h3C3, 10); push_tx(8'h81, 8); run(8); run(3); frame_end();

      chk("rx_queue_drained", 10'(rx_q.size()), 10'd0);
      chk("miso_queue_drained", 10'(miso_q.size()), 10'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave front end for the on-chip 256x8 RAM.
- Deserialises MOSI frames into 10-bit command words: {opcode[1:0], payload[7:0]}, plus a one-cycle rx_valid pulse for the RAM.
- On a read-data frame, serialises the RAM's 8-bit response onto MISO once the RAM raises tx_valid.
- Sits between the chip-level SPI pins and the RAM; it is the transmitter/receiver counterpart of the RAM command port.

Parameters:
- WORD_W, 10, command word width shifted in per frame (opcode + payload).
- TX_W, 8, response width shifted out on MISO.

Ports:
- clk  input  1  system clock; SPI bits are sampled one per rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low; high ends or aborts a frame.
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  WORD_W  assembled command word to RAM din.
- rx_valid  output  1  one-cycle strobe qualifying rx_data.
- tx_data  input  TX_W  RAM read data.
- tx_valid  input  1  RAM read data valid; level, may stay high.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; MISO=0, rx_data=0, rx_valid=0.
  - Bit counter=0; rd_addr_ok flag=0; sent flag=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- SS_n=1 sampled in any state: next state IDLE.
  - Counter and sent flag cleared; rx_valid=0; MISO=0.
  - rd_addr_ok is NOT cleared.
- IDLE: SS_n=0 -> CHK_CMD. No MOSI bit is consumed.
- CHK_CMD: MOSI sampled as the select bit (not shifted into the word).
  - 0 -> WRITE.
  - 1 and rd_addr_ok=0 -> READ_ADD.
  - 1 and rd_addr_ok=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA, word phase:
  - Each edge with SS_n=0 shifts MOSI into the LSB of the shift register; counter increments.
  - On the edge capturing the 10th bit: rx_data <= full word and rx_valid <= 1.
  - rx_valid returns to 0 on the next edge; it is never high for more than one cycle per frame.
  - Word contents are forwarded unchecked; the opcode is the RAM's concern.
- WRITE after the word: MOSI is ignored until SS_n=1.
- READ_ADD after the word: rd_addr_ok <= 1 on the same edge rx_valid rises; MOSI is ignored until SS_n=1.
- READ_DATA after the word, with sent=0:
  - Wait for tx_valid=1.
  - tx_valid seen while the word is still being shifted is ignored.
  - First edge with tx_valid=1: MISO <= tx_data[7]; the shift register loads tx_data.
  - The next 7 edges drive tx_data[6]..tx_data[0] on MISO.
  - Edge after bit 0: MISO <= 0, sent <= 1, rd_addr_ok <= 0.
  - No further tx_data load in this frame, even if tx_valid stays high.
- Abort in READ_DATA (SS_n=1 before bit 0 is driven): rd_addr_ok stays 1, so the next read frame is READ_DATA again.
- MISO is 0 whenever no response bit is being driven.
- Latency: rx_valid is high in the cycle after the 10th MOSI bit edge. The first MISO bit appears one edge after tx_valid is first sampled high.
- Reset mid-frame aborts immediately; the first frame after reset is treated as if no read address has been received.

Test Plan:
- Write address: SS_n=0, select 0, then word 0x03A (bits 00_0011_1010) -> rx_data=0x03A with rx_valid high for exactly 1 cycle after bit 10; MISO=0 throughout; SS_n=1 -> IDLE.
- Write data: select 0, then word 0x1C5 -> rx_data=0x1C5 with a single rx_valid pulse; no MISO activity.
- Read sequence:
  - Frame 1: select 1, word 0x210 -> READ_ADD path, rx_data=0x210, rd_addr_ok=1.
  - Frame 2: select 1, word 0x300, tx_valid held high with tx_data=0xA5 -> MISO shows 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0; rd_addr_ok=0.
  - Frame 3 with select 1 -> goes to READ_ADD.
- Abort:
  - SS_n=1 after 5 word bits in WRITE -> no rx_valid; IDLE.
  - Next full write frame 0x07F -> rx_valid once with 0x07F.
  - READ_DATA aborted after 3 MISO bits -> the next read frame re-enters READ_DATA.
- Reset mid-frame: rst_n=0 during READ_DATA bit 4 -> MISO=0, rx_valid=0, rx_data=0 immediately; the next read frame goes to READ_ADD.
- Held tx_valid: tx_valid=1 continuously across the whole READ_DATA frame -> exactly one 8-bit response after the 10-bit word, none during the word phase.
